// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-input round-robin arbiter feeding one registered output slot.
// Each cycle the slot is either empty or being drained. In that case the next
// requesting channel, searched cyclically from ptr, is accepted. A drain and a
// new accept can happen in the same cycle.
// Optional build macro RR_MUX_FORCE_EN adds force_en/force_sel. While
// force_en is high, only channel force_sel can be granted, and ptr is left
// untouched.
module rr_mux_arb #(
  parameter  int WIDTH = 64,
  parameter  int N     = 32,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data [N-1:0],
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef RR_MUX_FORCE_EN
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
`endif
  output logic [SEL_W-1:0] out_sel
);

  logic [SEL_W-1:0] ptr_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] out_sel_r;

  logic [SEL_W:0]   rr_res_s;
  logic [SEL_W-1:0] grant_s;
  logic             grant_vld_s;
  logic             forced_s;
  logic             load_s;
  logic [SEL_W-1:0] ptr_nxt_s;
  logic [N-1:0]     in_ready_s;

  // Cyclic search from ptr, returns {found, index}.
  // The candidate is computed one bit wider so that ptr+k never overflows
  // before it is folded back below N. This also works for non-power-of-2 N.
  function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0] ptr,
                                             input logic [N-1:0]     req);
    logic [SEL_W:0] sum;
    logic [SEL_W:0] cand;
    logic [SEL_W:0] res;
    res = '0;
    for (int k = 0; k < N; k++) begin
      sum  = {1'b0, ptr} + (SEL_W+1)'(k);
      cand = (sum >= (SEL_W+1)'(N)) ? (sum - (SEL_W+1)'(N)) : sum;
      res  = (!res[SEL_W] && req[cand[SEL_W-1:0]]) ? {1'b1, cand[SEL_W-1:0]} : res;
    end
    return res;
  endfunction

  // Grant selection: round-robin, or the forced channel when override is on.
  always_comb begin
    rr_res_s    = rr_pick(ptr_r, in_valid);
    grant_vld_s = rr_res_s[SEL_W];
    grant_s     = rr_res_s[SEL_W-1:0];
    forced_s    = 1'b0;
`ifdef RR_MUX_FORCE_EN
    if (force_en) begin
      forced_s = 1'b1;
      if (({1'b0, force_sel} < (SEL_W+1)'(N)) && in_valid[force_sel]) begin
        grant_vld_s = 1'b1;
        grant_s     = force_sel;
      end else begin
        grant_vld_s = 1'b0;
        grant_s     = '0;
      end
    end else begin
      forced_s = 1'b0;
    end
`endif
  end

  // Load when the slot is free or draining; never while reset is held.
  always_comb begin
    load_s    = reset_n && grant_vld_s && (!out_valid_r || out_ready);
    ptr_nxt_s = (grant_s == SEL_W'(N-1)) ? '0 : (grant_s + SEL_W'(1));
  end

  // One-hot accept toward the granted channel only.
  always_comb begin
    in_ready_s = '0;
    if (load_s) begin
      in_ready_s[grant_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_sel_r   <= '0;
    end else begin
      if (load_s) begin
        out_data_r  <= in_data[grant_s];
        out_sel_r   <= grant_s;
        out_valid_r <= 1'b1;
        if (!forced_s) begin
          ptr_r <= ptr_nxt_s;
        end
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed plus random checks of rr_mux_arb, using an N=32 and
// an N=6 instance. A queue-free arithmetic model tracks the pointer as an
// integer and derives each grant by a modulo-N search.
// Define RR_MUX_FORCE_EN to exercise the force override.
module tb_rr_mux_arb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [63:0] in_data32 [31:0];
  logic [31:0] in_valid32, in_ready32;
  logic [63:0] out_data32;
  logic        out_valid32, out_ready32;
  logic [4:0]  out_sel32;
  logic        fen32;
  logic [4:0]  fsel32;

  logic [7:0]  in_data6 [5:0];
  logic [5:0]  in_valid6, in_ready6;
  logic [7:0]  out_data6;
  logic        out_valid6, out_ready6;
  logic [2:0]  out_sel6;
  logic        fen6;
  logic [2:0]  fsel6;

  int          m32_ptr, m32_sel, m6_ptr, m6_sel;
  logic        m32_v, m6_v;
  logic [63:0] m32_data, m6_data;
  int          n_cmp, n_bad;

  rr_mux_arb #(.WIDTH(64), .N(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data32), .in_valid(in_valid32),
    .in_ready(in_ready32), .out_data(out_data32), .out_valid(out_valid32),
    .out_ready(out_ready32),
`ifdef RR_MUX_FORCE_EN
    .force_en(fen32), .force_sel(fsel32),
`endif
    .out_sel(out_sel32)
  );

  rr_mux_arb #(.WIDTH(8), .N(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .out_data(out_data6), .out_valid(out_valid6),
    .out_ready(out_ready6),
`ifdef RR_MUX_FORCE_EN
    .force_en(fen6), .force_sel(fsel6),
`endif
    .out_sel(out_sel6)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Granted channel per the arbitration rules, or -1 when nobody is granted.
  function automatic int pick(input int ptr, input logic [63:0] v, input int n,
                              input logic fen, input int fsel);
    if (fen) begin
      if (fsel < n && v[fsel]) return fsel;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m32_ptr = 0; m32_sel = 0; m32_v = 1'b0; m32_data = 64'd0;
    m6_ptr  = 0; m6_sel  = 0; m6_v  = 1'b0; m6_data  = 64'd0;
  endtask

  // One clock: check in_ready before the edge, update the model, check outputs.
  task automatic cycle();
    int   g32, g6;
    logic ld32, ld6;
    #1;
    g32  = pick(m32_ptr, {32'd0, in_valid32}, 32, fen32, int'(fsel32));
    ld32 = (!m32_v || out_ready32) && (g32 >= 0);
    check("in_ready32", {32'd0, in_ready32}, ld32 ? (64'd1 << g32) : 64'd0);
    g6   = pick(m6_ptr, {58'd0, in_valid6}, 6, fen6, int'(fsel6));
    ld6  = (!m6_v || out_ready6) && (g6 >= 0);
    check("in_ready6", {58'd0, in_ready6}, ld6 ? (64'd1 << g6) : 64'd0);
    @(posedge clk);
    if (ld32) begin
      m32_v = 1'b1; m32_sel = g32; m32_data = in_data32[g32];
      if (!fen32) m32_ptr = (g32 + 1) % 32;
    end else if (out_ready32) begin
      m32_v = 1'b0;
    end
    if (ld6) begin
      m6_v = 1'b1; m6_sel = g6; m6_data = {56'd0, in_data6[g6]};
      if (!fen6) m6_ptr = (g6 + 1) % 6;
    end else if (out_ready6) begin
      m6_v = 1'b0;
    end
    @(negedge clk);
    check("out_valid32", 64'(out_valid32), 64'(m32_v));
    check("out_sel32",   64'(out_sel32),   64'(m32_sel));
    check("out_data32",  out_data32,       m32_data);
    check("out_valid6",  64'(out_valid6),  64'(m6_v));
    check("out_sel6",    64'(out_sel6),    64'(m6_sel));
    check("out_data6",   64'(out_data6),   m6_data);
    check("sel6_range",  64'(out_sel6 < 3'd6), 64'd1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0;
    fen32 = 1'b0; fsel32 = 5'd0; fen6 = 1'b0; fsel6 = 3'd0;
    for (int j = 0; j < 32; j++) in_data32[j] = 64'(j);
    for (int j = 0; j < 6; j++)  in_data6[j]  = 8'(j * 3 + 1);
    in_valid32 = '1; in_valid6 = '1; out_ready32 = 1'b1; out_ready6 = 1'b1;
    model_reset();

    // Reset state with every channel requesting.
    #3;
    check("rst_valid32", 64'(out_valid32), 64'd0);
    check("rst_sel32",   64'(out_sel32),   64'd0);
    check("rst_data32",  out_data32,       64'd0);
    check("rst_ready32", 64'(in_ready32),  64'd0);
    check("rst_ready6",  64'(in_ready6),   64'd0);
    check("rst_valid6",  64'(out_valid6),  64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full sweep with wrap on N=32; channels 0 and 5 alternating on N=6.
    in_valid6 = 6'b100001;
    for (int i = 0; i < 34; i++) begin
      cycle();
      check("sweep_sel",  64'(out_sel32), 64'(i % 32));
      check("sweep_data", out_data32,     64'(i % 32));
      check("alt_sel6",   64'(out_sel6),  (i % 2 == 0) ? 64'd0 : 64'd5);
    end

    // Single continuous requester gets every cycle.
    in_valid32 = 32'h0000_0020;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("single_sel",   64'(out_sel32),  64'd5);
      check("single_ready", 64'(in_ready32), 64'h20);
    end

    // Asynchronous reset while a beat is held.
    check("pre_rst_valid", 64'(out_valid32), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid32", 64'(out_valid32), 64'd0);
    check("arst_sel32",   64'(out_sel32),   64'd0);
    check("arst_data32",  out_data32,       64'd0);
    check("arst_ready32", 64'(in_ready32),  64'd0);
    check("arst_valid6",  64'(out_valid6),  64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    in_valid32 = '1; in_valid6 = '1;
    cycle();
    check("post_rst_sel", 64'(out_sel32), 64'd0);

    // Backpressure: channel 3 held, then channel 7 on release.
    in_valid32 = 32'h0000_0088;
    cycle();
    check("bp_first_sel", 64'(out_sel32), 64'd3);
    out_ready32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_hold_sel",   64'(out_sel32),   64'd3);
      check("bp_hold_ready", 64'(in_ready32),  64'd0);
      check("bp_hold_valid", 64'(out_valid32), 64'd1);
    end
    out_ready32 = 1'b1;
    cycle();
    check("bp_next_sel", 64'(out_sel32), 64'd7);

`ifdef RR_MUX_FORCE_EN
    // Forced channel 9 repeatedly.
    in_valid32 = '1; fen32 = 1'b1; fsel32 = 5'd9;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("force_sel", 64'(out_sel32), 64'd9);
    end
    fen32 = 1'b0;
    // A force index beyond the channel count grants nothing (N=6, index 7).
    in_valid6 = '1; out_ready6 = 1'b1; fen6 = 1'b1; fsel6 = 3'd7;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("force_oor_valid", 64'(out_valid6), 64'd0);
    end
    fen6 = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid32  = (i % 3 == 0) ? $urandom : ($urandom & $urandom & $urandom);
      out_ready32 = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 32; j++) in_data32[j] = {$urandom, $urandom};
      in_valid6   = 6'($urandom) & 6'($urandom);
      out_ready6  = 1'($urandom_range(0, 1));
      for (int j = 0; j < 6; j++) in_data6[j] = 8'($urandom);
`ifdef RR_MUX_FORCE_EN
      fen32 = ($urandom_range(0, 7) == 0); fsel32 = 5'($urandom);
      fen6  = ($urandom_range(0, 7) == 0); fsel6  = 3'($urandom);
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
